ddr_mem_arbiter: RTL

//  Arbitrates instruction-fetch burst reads (512b) and LSU single accesses
//  (64b rd/wr) onto the one simddr port. Latches the winning request, holds
//  all DDR controls stable for the whole op, and returns data with a 1-cycle

---
 rtl/ddr_mem_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ddr_mem_arbiter.sv
// ddr_mem_arbiter: shares the single simddr port between fetch burst reads and LSU accesses.
// Define ARB_ROUND_ROBIN_EN to alternate grants on simultaneous requests (default: mem over fetch).
module ddr_mem_arbiter #(
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned BURST_W = 512,
  parameter int unsigned DATA_W  = 64
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_fetch_req,
  input  logic [ADDR_W-1:0]  i_fetch_addr,
  input  logic               i_fetch_flush,
  output logic               o_fetch_done,
  output logic [BURST_W-1:0] o_fetch_data,
  input  logic               i_mem_req,
  input  logic               i_mem_we,
  input  logic [ADDR_W-1:0]  i_mem_addr,
  input  logic [DATA_W-1:0]  i_mem_wdata,
  output logic               o_mem_done,
  output logic [DATA_W-1:0]  o_mem_rdata,
  output logic               o_ddr_chip_enable,
  output logic               o_ddr_write_enable,
  output logic               o_ddr_burst_mode,
  output logic [ADDR_W-1:0]  o_ddr_address,
  output logic [BURST_W-1:0] o_ddr_l2_burst_write_data,
  output logic [DATA_W-1:0]  o_ddr_access_write_data,
  input  logic [BURST_W-1:0] i_ddr_fetch_burst_read_inst,
  input  logic [DATA_W-1:0]  i_ddr_access_read_data,
  input  logic               i_ddr_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_owner_fetch;
  logic   r_kill;
  logic   w_fetch_ok;
  logic   w_grant_mem;
  logic   w_grant_fetch;
  logic   w_kill_now;

  // A flush in the same cycle blocks a fetch grant
  assign w_fetch_ok = i_fetch_req & ~i_fetch_flush;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_fetch;

  always_comb begin
    w_grant_mem   = i_mem_req;
    w_grant_fetch = w_fetch_ok;
    if (i_mem_req && w_fetch_ok) begin
      w_grant_mem   = r_last_fetch;
      w_grant_fetch = ~r_last_fetch;
    end
  end

  // Reset value "fetch" makes mem win the first tie
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last_fetch <= 1'b1;
    end else if (r_state == S_IDLE && (w_grant_mem || w_grant_fetch)) begin
      r_last_fetch <= w_grant_fetch;
    end
  end
`else
  assign w_grant_mem   = i_mem_req;
  assign w_grant_fetch = w_fetch_ok & ~i_mem_req;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_mem || w_grant_fetch) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (i_ddr_ready) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Chip enable must fall in the very cycle ready is seen, else simddr restarts
  assign o_ddr_chip_enable = (r_state == S_ISSUE) | ((r_state == S_WAIT) & ~i_ddr_ready);
  assign o_ddr_l2_burst_write_data = '0;

  assign w_kill_now = r_kill | i_fetch_flush;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_owner_fetch           <= 1'b0;
      r_kill                  <= 1'b0;
      o_ddr_write_enable      <= 1'b0;
      o_ddr_burst_mode        <= 1'b0;
      o_ddr_address           <= '0;
      o_ddr_access_write_data <= '0;
      o_fetch_done            <= 1'b0;
      o_fetch_data            <= '0;
      o_mem_done              <= 1'b0;
      o_mem_rdata             <= '0;
    end else begin
      o_fetch_done <= 1'b0;
      o_mem_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_kill <= 1'b0;
          if (w_grant_mem) begin
            r_owner_fetch           <= 1'b0;
            o_ddr_write_enable      <= i_mem_we;
            o_ddr_burst_mode        <= 1'b0;
            o_ddr_address           <= i_mem_addr;
            o_ddr_access_write_data <= i_mem_wdata;
          end else if (w_grant_fetch) begin
            r_owner_fetch      <= 1'b1;
            o_ddr_write_enable <= 1'b0;
            o_ddr_burst_mode   <= 1'b1;
            o_ddr_address      <= i_fetch_addr;
          end
        end
        S_ISSUE, S_RESP: begin
          if (r_owner_fetch && i_fetch_flush) r_kill <= 1'b1;
        end
        S_WAIT: begin
          if (r_owner_fetch && i_fetch_flush) r_kill <= 1'b1;
          if (i_ddr_ready) begin
            if (r_owner_fetch) begin
              if (!w_kill_now) begin
                o_fetch_done <= 1'b1;
                o_fetch_data <= i_ddr_fetch_burst_read_inst;
              end
            end else begin
              o_mem_done <= 1'b1;
              if (!o_ddr_write_enable) o_mem_rdata <= i_ddr_access_read_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
